// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter, phase bit and instruction register; optional macro PC_WRAP_TRAP_EN
module pc_sequencer (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  PS,
   input  logic        NS,
   input  logic        ROM_enable,
   input  logic [7:0]  target_addr,
   input  logic [7:0]  reg_addr,
   input  logic [15:0] rom_data,
   output logic [7:0]  pc,
   output logic [7:0]  pc_plus1,
   output logic        state,
   output logic [15:0] ir,
   output logic        halted,
   output logic        wrap_err
);

   logic [7:0]  pc_q, pc_d;
   logic        state_q, state_d;
   logic [15:0] ir_q, ir_d;
   logic        halted_q, halted_d;
   logic        halt_req;
`ifdef PC_WRAP_TRAP_EN
   logic        wrap_err_q, wrap_err_d;
`endif

   assign pc_plus1 = pc_q + 8'd1;
   assign halt_req = (PS == 2'b00) && !NS && !ROM_enable;

   always_comb begin
      pc_d     = pc_q;
      state_d  = state_q;
      ir_d     = ir_q;
      halted_d = halted_q;
`ifdef PC_WRAP_TRAP_EN
      wrap_err_d = wrap_err_q;
`endif
      // Once halted, nothing but reset moves the sequencer.
      if (!halted_q) begin
         if (halt_req) begin
            halted_d = 1'b1;
         end else begin
            state_d = NS;
            if (ROM_enable)
               ir_d = rom_data;
            case (PS)
               2'b01: begin
`ifdef PC_WRAP_TRAP_EN
                  if (pc_q == 8'hFF) begin
                     wrap_err_d = 1'b1;
                     halted_d   = 1'b1;
                  end else begin
                     pc_d = pc_plus1;
                  end
`else
                  pc_d = pc_plus1;
`endif
               end
               2'b10:   pc_d = target_addr;
               2'b11:   pc_d = reg_addr;
               default: pc_d = pc_q;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q     <= 8'h00;
         state_q  <= 1'b0;
         ir_q     <= 16'h0000;
         halted_q <= 1'b0;
`ifdef PC_WRAP_TRAP_EN
         wrap_err_q <= 1'b0;
`endif
      end else begin
         pc_q     <= pc_d;
         state_q  <= state_d;
         ir_q     <= ir_d;
         halted_q <= halted_d;
`ifdef PC_WRAP_TRAP_EN
         wrap_err_q <= wrap_err_d;
`endif
      end
   end

   assign pc     = pc_q;
   assign state  = state_q;
   assign ir     = ir_q;
   assign halted = halted_q;
`ifdef PC_WRAP_TRAP_EN
   assign wrap_err = wrap_err_q;
`else
   assign wrap_err = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed vector bench for pc_sequencer
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  PS;
   logic        NS;
   logic        ROM_enable;
   logic [7:0]  target_addr;
   logic [7:0]  reg_addr;
   logic [15:0] rom_data;
   logic [7:0]  pc;
   logic [7:0]  pc_plus1;
   logic        state;
   logic [15:0] ir;
   logic        halted;
   logic        wrap_err;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   pc_sequencer dut (
      .clk(clk), .rst(rst), .PS(PS), .NS(NS), .ROM_enable(ROM_enable),
      .target_addr(target_addr), .reg_addr(reg_addr), .rom_data(rom_data),
      .pc(pc), .pc_plus1(pc_plus1), .state(state), .ir(ir),
      .halted(halted), .wrap_err(wrap_err)
   );

   typedef struct {
      logic        r;
      logic [1:0]  ps;
      logic        ns;
      logic        en;
      logic [7:0]  tgt;
      logic [7:0]  rga;
      logic [15:0] rom;
      logic [7:0]  e_pc;
      logic        e_st;
      logic [15:0] e_ir;
      logic        e_h;
      logic        e_w;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d] got %h expected %h", nm, idx, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic [1:0] ps, input logic ns, input logic en,
                        input logic [7:0] tgt, input logic [7:0] rga, input logic [15:0] rom);
      rst = r; PS = ps; NS = ns; ROM_enable = en;
      target_addr = tgt; reg_addr = rga; rom_data = rom;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_all(input string nm, input int idx, input logic [7:0] e_pc, input logic e_st,
                             input logic [15:0] e_ir, input logic e_h, input logic e_w);
      logic [7:0] e_p1;
      e_p1 = e_pc + 8'd1;
      chk({nm, ".pc"}, idx, {8'h00, pc}, {8'h00, e_pc});
      chk({nm, ".pc_plus1"}, idx, {8'h00, pc_plus1}, {8'h00, e_p1});
      chk({nm, ".state"}, idx, {15'h0, state}, {15'h0, e_st});
      chk({nm, ".ir"}, idx, ir, e_ir);
      chk({nm, ".halted"}, idx, {15'h0, halted}, {15'h0, e_h});
      chk({nm, ".wrap_err"}, idx, {15'h0, wrap_err}, {15'h0, e_w});
   endtask

   initial begin
      //                r     ps     ns    en    tgt    rga    rom       pc     st    ir        h     w
      vecs.push_back('{1'b1, 2'b01, 1'b0, 1'b0, 8'h00, 8'h00, 16'h0000, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 2'b01, 1'b1, 1'b1, 8'h00, 8'h00, 16'h9999, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 2'b01, 1'b0, 1'b1, 8'h00, 8'h00, 16'h1111, 8'h01, 1'b0, 16'h1111, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 2'b10, 1'b0, 1'b0, 8'h04, 8'h00, 16'h2222, 8'h04, 1'b0, 16'h1111, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 2'b01, 1'b0, 1'b1, 8'h00, 8'h00, 16'hA5C3, 8'h05, 1'b0, 16'hA5C3, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 2'b10, 1'b0, 1'b0, 8'h10, 8'h00, 16'h0000, 8'h10, 1'b0, 16'hA5C3, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 2'b10, 1'b1, 1'b0, 8'h3C, 8'h00, 16'h3333, 8'h3C, 1'b1, 16'hA5C3, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 2'b01, 1'b0, 1'b0, 8'h00, 8'h00, 16'h0000, 8'h3D, 1'b0, 16'hA5C3, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 2'b11, 1'b1, 1'b1, 8'h00, 8'h7E, 16'hBEEF, 8'h7E, 1'b1, 16'hBEEF, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 2'b00, 1'b1, 1'b0, 8'h55, 8'h66, 16'h0000, 8'h7E, 1'b1, 16'hBEEF, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 2'b00, 1'b0, 1'b1, 8'h55, 8'h66, 16'h1234, 8'h7E, 1'b0, 16'h1234, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 2'b10, 1'b0, 1'b0, 8'hFE, 8'h00, 16'h0000, 8'hFE, 1'b0, 16'h1234, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 2'b01, 1'b0, 1'b0, 8'h00, 8'h00, 16'h0000, 8'hFF, 1'b0, 16'h1234, 1'b0, 1'b0});
`ifdef PC_WRAP_TRAP_EN
      vecs.push_back('{1'b0, 2'b01, 1'b0, 1'b0, 8'h00, 8'h00, 16'h0000, 8'hFF, 1'b0, 16'h1234, 1'b1, 1'b1});
`else
      vecs.push_back('{1'b0, 2'b01, 1'b0, 1'b0, 8'h00, 8'h00, 16'h0000, 8'h00, 1'b0, 16'h1234, 1'b0, 1'b0});
`endif

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].r, vecs[i].ps, vecs[i].ns, vecs[i].en, vecs[i].tgt, vecs[i].rga, vecs[i].rom);
         expect_all("vec", i, vecs[i].e_pc, vecs[i].e_st, vecs[i].e_ir, vecs[i].e_h, vecs[i].e_w);
      end

      // End-of-execution with state=1 in flight: halt must freeze state, pc and ir.
      drive(1'b1, 2'b00, 1'b0, 1'b0, 8'h00, 8'h00, 16'h0000);
      expect_all("eoe_rst", 0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0);
      drive(1'b0, 2'b10, 1'b1, 1'b1, 8'h22, 8'h00, 16'hC0DE);
      expect_all("eoe_load", 0, 8'h22, 1'b1, 16'hC0DE, 1'b0, 1'b0);
      drive(1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 8'h00, 16'h0000);
      expect_all("eoe_halt", 0, 8'h22, 1'b1, 16'hC0DE, 1'b1, 1'b0);
      for (int k = 0; k < 10; k++) begin
         drive(1'b0, 2'b01, 1'b0, 1'b1, 8'h99, 8'h88, 16'hFFFF);
         expect_all("eoe_frozen", k, 8'h22, 1'b1, 16'hC0DE, 1'b1, 1'b0);
      end
      drive(1'b1, 2'b10, 1'b1, 1'b1, 8'h77, 8'h00, 16'hAAAA);
      expect_all("eoe_clear", 0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0);

      // Reset beats a branch in progress (state=1), then fetch restarts at 00.
      drive(1'b0, 2'b10, 1'b1, 1'b0, 8'h40, 8'h00, 16'h0000);
      expect_all("midbr", 0, 8'h40, 1'b1, 16'h0000, 1'b0, 1'b0);
      drive(1'b1, 2'b10, 1'b1, 1'b1, 8'h50, 8'h00, 16'h5555);
      expect_all("midbr_rst", 0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0);
      drive(1'b0, 2'b01, 1'b0, 1'b1, 8'h00, 8'h00, 16'h0F0F);
      expect_all("resume", 0, 8'h01, 1'b0, 16'h0F0F, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
